sp_div_signed: RTL and testbench

- Multi-cycle, radix-2 restoring signed integer divider for the arithmetic library, parameterised by WIDTH.
- Computes a / b on two's-complement operands, truncating toward zero to match Verilog signed `/`.
- Uses the library's common handshake: operands, result and a ready flag; no start strobe.
- A computation begins on reset release or when the operands change.

---
 rtl/sp_arith_pkg.sv | 25 ++
 rtl/sp_div_step.sv | 27 ++
 rtl/sp_div_signed.sv | 103 ++++++++++
 tb/tb_sp_div_signed.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sp_arith_pkg.sv
// Shared arithmetic-library definitions: divider state encoding, default width
// and two's-complement helpers usable by any operand width up to MAX_W.
package sp_arith_pkg;

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } div_state_e;

   localparam int DEF_WIDTH = 32;
   localparam int MAX_W     = 64;

   // Callers sign- or zero-extend into MAX_W bits and truncate the return value,
   // which keeps the low WIDTH bits exact for any WIDTH <= MAX_W.
   function automatic logic [MAX_W-1:0] sp_cond_neg(input logic [MAX_W-1:0] v,
                                                   input logic             neg);
      return neg ? (~v + MAX_W'(1)) : v;
   endfunction

   function automatic logic [MAX_W-1:0] sp_mag(input logic signed [MAX_W-1:0] v);
      return sp_cond_neg(v, v[MAX_W-1]);
   endfunction

endpackage

// File: rtl/sp_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial
// subtract the divisor, keep the difference only if it did not go negative.
module sp_div_step
   import sp_arith_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic             dvd_bit_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] rem_o,
   output logic             q_bit_o
);

   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] shifted;

   // The compare needs the full WIDTH+1 bits, but when it succeeds the
   // difference is below the divisor, so WIDTH-bit modular subtraction suffices.
   always_comb begin
      trial   = {rem_i, dvd_bit_i};
      shifted = {rem_i[WIDTH-2:0], dvd_bit_i};
      q_bit_o = (trial >= {1'b0, divisor_i});
      rem_o   = q_bit_o ? (shifted - divisor_i) : shifted;
   end

endmodule

// File: rtl/sp_div_signed.sv
// Multi-cycle radix-2 restoring signed divider, truncating toward zero; restarts
// automatically on reset release or whenever the operands change in DONE.
module sp_div_signed
   import sp_arith_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic signed [WIDTH-1:0] a,
   input  logic signed [WIDTH-1:0] b,
   output logic signed [WIDTH-1:0] result,
   output logic                    ready
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   div_state_e              state_q;
   logic signed [WIDTH-1:0] a_q;
   logic signed [WIDTH-1:0] b_q;
   logic [WIDTH-1:0]        dvd_q;
   logic [WIDTH-1:0]        div_q;
   logic [WIDTH-1:0]        rem_q;
   logic                    sign_q;
   logic                    zero_q;
   logic [CNT_W-1:0]        cnt_q;
   logic signed [WIDTH-1:0] result_q;
   logic                    ready_q;

   logic [WIDTH-1:0]        amag_d;
   logic [WIDTH-1:0]        bmag_d;
   logic [WIDTH-1:0]        rem_d;
   logic                    qbit_d;
   logic [WIDTH-1:0]        quot_fix_d;
   logic                    load_d;

   assign amag_d = WIDTH'(sp_mag(MAX_W'(a)));
   assign bmag_d = WIDTH'(sp_mag(MAX_W'(b)));

   // Divide by zero is forced to all ones regardless of the dividend sign.
   assign quot_fix_d = zero_q ? '1 : WIDTH'(sp_cond_neg(MAX_W'(dvd_q), sign_q));

   assign load_d = (state_q == LOAD) ||
                   ((state_q == DONE) && ((a != a_q) || (b != b_q)));

   sp_div_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .rem_i     (rem_q),
      .dvd_bit_i (dvd_q[WIDTH-1]),
      .divisor_i (div_q),
      .rem_o     (rem_d),
      .q_bit_o   (qbit_d)
   );

   // dvd_q shifts the dividend out at the top while quotient bits enter at the bottom.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= LOAD;
         a_q      <= '0;
         b_q      <= '0;
         dvd_q    <= '0;
         div_q    <= '0;
         rem_q    <= '0;
         sign_q   <= 1'b0;
         zero_q   <= 1'b0;
         cnt_q    <= '0;
         result_q <= '0;
         ready_q  <= 1'b0;
      end else if (load_d) begin
         a_q     <= a;
         b_q     <= b;
         dvd_q   <= amag_d;
         div_q   <= bmag_d;
         rem_q   <= '0;
         sign_q  <= a[WIDTH-1] ^ b[WIDTH-1];
         zero_q  <= (b == '0);
         cnt_q   <= CNT_W'(WIDTH);
         ready_q <= 1'b0;
         state_q <= BUSY;
      end else begin
         case (state_q)
            BUSY: begin
               if (cnt_q != '0) begin
                  rem_q <= rem_d;
                  dvd_q <= {dvd_q[WIDTH-2:0], qbit_d};
                  cnt_q <= cnt_q - CNT_W'(1);
               end else begin
                  result_q <= quot_fix_d;
                  ready_q  <= 1'b1;
                  state_q  <= DONE;
               end
            end
            DONE:    state_q <= DONE;
            default: state_q <= LOAD;
         endcase
      end
   end

   assign result = result_q;
   assign ready  = ready_q;

endmodule

// File: tb/tb_sp_div_signed.sv
// Scoreboard bench for sp_div_signed: directed and random divisions, expected
// quotient and ready edge queued at issue time, checked when ready rises.
module tb_sp_div_signed;

   localparam int W   = 32;
   localparam int LAT = W + 2;

   typedef struct {
      logic signed [W-1:0] res;
      int                  edge_no;
   } exp_t;

   logic                clk = 1'b0;
   logic                rst;
   logic signed [W-1:0] a;
   logic signed [W-1:0] b;
   logic signed [W-1:0] result;
   logic                ready;

   exp_t exp_q[$];
   int   edge_cnt = 0;
   int   n_cmp    = 0;
   int   n_err    = 0;
   logic prev_rdy = 1'b0;

   sp_div_signed #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .a      (a),
      .b      (b),
      .result (result),
      .ready  (ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   // Reference: 64-bit signed division truncates toward zero; taking the low
   // W bits gives the natural wrap for most-negative / -1.
   function automatic logic signed [W-1:0] ref_div(input logic signed [W-1:0] x,
                                                   input logic signed [W-1:0] y);
      longint q;
      if (y == 0) return '1;
      q = longint'(x) / longint'(y);
      return q[W-1:0];
   endfunction

   task automatic check(input string name, input logic signed [W-1:0] act,
                        input logic signed [W-1:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic check_int(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic push_exp(input logic signed [W-1:0] res, input int edge_no);
      exp_t e;
      e.res     = res;
      e.edge_no = edge_no;
      exp_q.push_back(e);
   endtask

   // Monitor: every rising of ready consumes one expectation.
   always @(negedge clk) begin
      exp_t e;
      if (ready === 1'b1 && prev_rdy !== 1'b1) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_ready: result=%0d at edge %0d, no pending operation", result, edge_cnt);
         end else begin
            e = exp_q.pop_front();
            check("sb_result", result, e.res);
            check_int("sb_ready_edge", edge_cnt, e.edge_no);
         end
      end
      prev_rdy <= ready;
   end

   task automatic issue(input logic signed [W-1:0] x, input logic signed [W-1:0] y,
                        output int start_edge);
      @(negedge clk);
      a = x;
      b = y;
      start_edge = edge_cnt;
      push_exp(ref_div(x, y), edge_cnt + LAT);
   endtask

   // Issue while in DONE: ready must drop on the next edge, result must hold.
   task automatic issue_restart(input string name, input logic signed [W-1:0] x,
                                input logic signed [W-1:0] y, output int start_edge);
      logic signed [W-1:0] old;
      old = result;
      issue(x, y, start_edge);
      @(negedge clk);
      check({name, "_ready_drop"}, W'(ready), W'(1'b0));
      check({name, "_result_hold"}, result, old);
   endtask

   task automatic wait_ready(input string name);
      int k;
      k = 0;
      @(negedge clk);
      while (ready !== 1'b1 && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (ready !== 1'b1) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s_timeout: ready=%b after %0d cycles, required 1", name, ready, k);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, got edge %0d, expected finish", edge_cnt);
      $fatal(1, "watchdog");
   end

   initial begin
      int                  se;
      int                  t;
      logic signed [W-1:0] x;
      logic signed [W-1:0] y;

      rst = 1'b0;
      a   = -32'sd1234124124;
      b   = 32'sd134123;
      repeat (3) @(negedge clk);
      check("reset_result", result, '0);
      check("reset_ready", W'(ready), W'(1'b0));

      @(negedge clk);
      rst = 1'b1;
      push_exp(ref_div(a, b), edge_cnt + LAT);
      wait_ready("tp1");
      check("tp1_value", result, -32'sd9201);
      repeat (3) @(negedge clk);
      check("done_hold_ready", W'(ready), W'(1'b1));
      check("done_hold_result", result, -32'sd9201);

      issue_restart("tp2a", 32'sd7, -32'sd2, se);
      wait_ready("tp2a");
      check("tp2a_value", result, -32'sd3);
      issue_restart("tp2b", -32'sd7, 32'sd2, se);
      wait_ready("tp2b");
      check("tp2b_value", result, -32'sd3);

      issue_restart("div0", 32'sd100, 32'sd0, se);
      wait_ready("div0");
      check("div0_value", result, 32'hFFFF_FFFF);

      issue_restart("ovf", 32'h8000_0000, -32'sd1, se);
      wait_ready("ovf");
      check("ovf_value", result, 32'h8000_0000);
      issue_restart("minp1", 32'h8000_0000, 32'sd1, se);
      wait_ready("minp1");
      check("minp1_value", result, 32'h8000_0000);

      // Reset in the middle of a division aborts it; the pending expectation goes too.
      issue(32'sd1000, 32'sd7, se);
      repeat (9) @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      #1;
      check("midrst_result", result, '0);
      check("midrst_ready", W'(ready), W'(1'b0));
      repeat (2) @(negedge clk);
      check("midrst_hold_result", result, '0);
      check("midrst_hold_ready", W'(ready), W'(1'b0));
      rst = 1'b1;
      push_exp(ref_div(a, b), edge_cnt + LAT);
      wait_ready("midrst");
      check("midrst_value", result, 32'sd142);

      // Divisor change while busy is ignored until DONE, then restarts.
      issue_restart("busychg", 32'sd50, 32'sd5, se);
      repeat (3) @(negedge clk);
      b = 32'sd10;
      push_exp(ref_div(32'sd50, 32'sd10), se + 2 * LAT);
      wait_ready("busychg1");
      check("busychg1_value", result, 32'sd10);
      @(negedge clk);
      check("busychg_restart_drop", W'(ready), W'(1'b0));
      wait_ready("busychg2");
      check("busychg2_value", result, 32'sd5);

      for (int i = 0; i < 16; i++) begin
         x = $urandom;
         if ($urandom_range(0, 2) == 0) begin
            t = int'($urandom_range(0, 20)) - 10;
            y = t;
         end else begin
            y = $urandom;
         end
         if (x == a && y == b) y = y + 1;
         issue_restart("rand", x, y, se);
         wait_ready("rand");
      end

      repeat (5) @(negedge clk);
      check_int("scoreboard_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
